// File: rtl/scp_run_ctrl.sv
// ---------------------------------------------------------------------------
// scp_run_ctrl: run/boot sequencer for the single-cycle processor core.
//
// Loads a program into instruction memory over a valid/ready stream and then
// releases the core from reset. While the core runs, it can free-run or
// advance one instruction per step pulse. Execution stops on a HALT opcode,
// on reaching a cycle limit, or when a program overflows instruction memory.
// The number of executed cycles and the stop cause are reported.
//
// Ports:
//   clk, rstb              clock (rising edge), synchronous active-high reset
//   start                  pulse: begin a program load (IDLE/DONE only)
//   load_valid/ready/data/last  program word stream
//   imem_we/addr/wdata     instruction-memory write port
//   instr                  instruction currently fetched by the core
//   step_mode, step        single-step control
//   core_rst, core_en      core reset hold and per-cycle update enable
//   done, halt_cause       run finished; 00 none, 01 HALT, 10 limit, 11 overflow
//   cycle_count            number of enabled core cycles
// ---------------------------------------------------------------------------
module scp_run_ctrl #(
  parameter int unsigned IMEM_AW    = 8,
  parameter logic [31:0] MAX_CYCLES = 32'd100000,
  parameter logic [31:0] HALT_INSTR = 32'hFC000000
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [31:0]        load_data,
  input  logic               load_last,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  input  logic [31:0]        instr,
  input  logic               step_mode,
  input  logic               step,
  output logic               core_rst,
  output logic               core_en,
  output logic               done,
  output logic [1:0]         halt_cause,
  output logic [31:0]        cycle_count
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [1:0] CauseNone  = 2'b00;
  localparam logic [1:0] CauseHalt  = 2'b01;
  localparam logic [1:0] CauseLimit = 2'b10;
  localparam logic [1:0] CauseOvf   = 2'b11;

  localparam logic [IMEM_AW-1:0] AddrMax = '1;

  logic [1:0]         state_q, state_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        count_q, count_d;
  logic [1:0]         cause_q, cause_d;

  logic is_halt;
  logic run_en;
  logic [31:0] count_inc;

  assign is_halt   = (instr == HALT_INSTR);
  // A HALT cycle is never enabled, so HALT and the cycle limit are exclusive.
  assign run_en    = (state_q == StRun) && (!step_mode || step) && !is_halt;
  assign count_inc = count_q + 32'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    cause_d = cause_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          addr_d  = '0;
          count_d = '0;
          cause_d = CauseNone;
        end
      end
      StLoad: begin
        if (load_valid) begin
          addr_d = addr_q + 1'b1;
          if (load_last) begin
            state_d = StRun;
          end else if (addr_q == AddrMax) begin
            // Final slot written without load_last: program does not fit.
            state_d = StDone;
            cause_d = CauseOvf;
          end
        end
      end
      StRun: begin
        if (is_halt) begin
          state_d = StDone;
          cause_d = CauseHalt;
        end else if (run_en) begin
          count_d = count_inc;
          if (count_inc == MAX_CYCLES) begin
            state_d = StDone;
            cause_d = CauseLimit;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      cause_q <= CauseNone;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      cause_q <= cause_d;
    end
  end

  // Strobes are masked by rstb so a reset landing mid-LOAD/RUN takes effect
  // in the same cycle rather than one edge later.
  assign load_ready  = !rstb && (state_q == StLoad);
  assign imem_we     = load_ready && load_valid;
  assign imem_addr   = addr_q;
  assign imem_wdata  = load_data;
  assign core_en     = !rstb && run_en;
  assign core_rst    = rstb || (state_q == StIdle) || (state_q == StLoad);
  assign done        = !rstb && (state_q == StDone);
  assign halt_cause  = cause_q;
  assign cycle_count = count_q;

endmodule
